// File: rtl/alu_iter.sv
// Multi-cycle ALU: operand conditioning, add/and, iterative shift-add multiply
// and restoring divide, output inversion, with busy/done handshake and flags.
module alu_iter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             cmp_mode_wr,
  input  logic             sign_mode_wr,
  input  logic             mode_val,
  input  logic             oe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] remout,
  output logic             carryout,
  output logic             overout,
  output logic             zero,
  output logic             neg,
  output logic             div0,
  output logic             cmpo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_EXEC = 2'd2,
    S_POST = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] W_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [9:0]         ctrl_q, ctrl_d;
  logic               ci_q, ci_d;
  logic               cmp_mode_q, cmp_mode_d;
  logic               signed_q, signed_d;
  logic [WIDTH-1:0]   ap_q, ap_d;
  logic [WIDTH-1:0]   bp_q, bp_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   md_q, md_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               carry_q, carry_d;
  logic               over_q, over_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;
  logic               cmpo_q, cmpo_d;

  logic               is_mul, is_div, iter_op;
  logic [WIDTH-1:0]   ap_prep, bp_prep, a_mag, b_mag;
  logic [WIDTH:0]     mul_add, div_shift, div_trial, sum_w;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, r_pre, r_fin;
  logic               b_zero, div_ovf, sum_carry, r_ovf;

  always_comb begin
    is_mul  = (ctrl_q[9:8] == 2'd2);
    is_div  = (ctrl_q[9:8] == 2'd3);
    iter_op = ctrl_q[9];

    ap_prep = (ctrl_q[0] ? {WIDTH{1'b0}} : ap_q) ^ {WIDTH{ctrl_q[1]}};
    bp_prep = (ctrl_q[2] ? {WIDTH{1'b0}} : bp_q) ^ {WIDTH{ctrl_q[3]}};
    a_mag   = (signed_q & iter_op & ap_prep[WIDTH-1]) ? -ap_prep : ap_prep;
    b_mag   = (signed_q & iter_op & bp_prep[WIDTH-1]) ? -bp_prep : bp_prep;

    mul_add   = hi_q + {1'b0, (lo_q[0] ? md_q : {WIDTH{1'b0}})};
    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, md_q};

    sum_w = {1'b0, ap_q} + {1'b0, bp_q} + {{WIDTH{1'b0}}, ctrl_q[5]}
          + {{WIDTH{1'b0}}, cmp_mode_q & ctrl_q[7] & ci_q};
    sum_carry = ((ctrl_q[1] | ctrl_q[3]) & ctrl_q[5]) ? ~sum_w[WIDTH] : sum_w[WIDTH];

    // Iteration ran on magnitudes; restore signs here.
    prod    = {hi_q[WIDTH-1:0], lo_q};
    prod_s  = (signed_q & (sa_q ^ sb_q)) ? -prod : prod;
    quo_s   = (signed_q & (sa_q ^ sb_q)) ? -lo_q : lo_q;
    rem_s   = (signed_q & sa_q) ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
    b_zero  = (bp_q == '0);
    div_ovf = signed_q & (ap_q == W_MIN) & (bp_q == '1);

    case (ctrl_q[9:8])
      2'd0:    r_pre = sum_w[WIDTH-1:0];
      2'd1:    r_pre = ap_q & bp_q;
      2'd2:    r_pre = ctrl_q[6] ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
      default: r_pre = b_zero ? {WIDTH{1'b1}} : quo_s;
    endcase
    r_fin = r_pre ^ {WIDTH{ctrl_q[4]}};

    case (ctrl_q[9:8])
      2'd2:    r_ovf = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
      2'd3:    r_ovf = div_ovf;
      default: r_ovf = (~r_fin[WIDTH-1] & ap_q[WIDTH-1] & bp_q[WIDTH-1])
                     | (r_fin[WIDTH-1] & ~ap_q[WIDTH-1] & ~bp_q[WIDTH-1]);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    ci_d       = ci_q;
    cmp_mode_d = cmp_mode_q;
    signed_d   = signed_q;
    ap_d       = ap_q;
    bp_d       = bp_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    md_d       = md_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    rem_d      = rem_q;
    carry_d    = carry_q;
    over_d     = over_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    div0_d     = div0_q;
    done_d     = 1'b0;
    cmpo_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmp_mode_wr)  cmp_mode_d = mode_val;
        if (sign_mode_wr) signed_d   = mode_val;
        if (start) begin
          ctrl_d  = ctrl;
          ap_d    = a;
          bp_d    = b;
          ci_d    = carryin;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        ap_d  = ap_prep;
        bp_d  = bp_prep;
        sa_d  = ap_prep[WIDTH-1];
        sb_d  = bp_prep[WIDTH-1];
        hi_d  = '0;
        cnt_d = CNT_LOAD;
        if (is_div) begin
          lo_d = a_mag;
          md_d = b_mag;
        end else begin
          lo_d = b_mag;
          md_d = a_mag;
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Iterative ops leave one cycle after the counter empties.
        if (!iter_op || cnt_q == '0) begin
          state_d = S_POST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (is_mul) begin
            hi_d = {1'b0, mul_add[WIDTH:1]};
            lo_d = {mul_add[0], lo_q[WIDTH-1:1]};
          end else if (!div_trial[WIDTH]) begin
            hi_d = div_trial;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_shift;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      S_POST: begin
        res_d   = r_fin;
        rem_d   = is_div ? (b_zero ? ap_q : rem_s) : '0;
        carry_d = (ctrl_q[9:8] == 2'd0) & sum_carry;
        over_d  = r_ovf;
        zero_d  = (r_fin == '0);
        neg_d   = r_fin[WIDTH-1];
        div0_d  = is_div & b_zero;
        done_d  = 1'b1;
        cmpo_d  = ctrl_q[7];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      ci_q       <= 1'b0;
      cmp_mode_q <= 1'b0;
      signed_q   <= 1'b0;
      ap_q       <= '0;
      bp_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      md_q       <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      rem_q      <= '0;
      carry_q    <= 1'b0;
      over_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      div0_q     <= 1'b0;
      done_q     <= 1'b0;
      cmpo_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      ci_q       <= ci_d;
      cmp_mode_q <= cmp_mode_d;
      signed_q   <= signed_d;
      ap_q       <= ap_d;
      bp_q       <= bp_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      md_q       <= md_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      rem_q      <= rem_d;
      carry_q    <= carry_d;
      over_q     <= over_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      div0_q     <= div0_d;
      done_q     <= done_d;
      cmpo_q     <= cmpo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign aluout   = oe ? res_q : '0;
  assign remout   = oe ? rem_q : '0;
  assign carryout = carry_q;
  assign overout  = over_q;
  assign zero     = zero_q;
  assign neg      = neg_q;
  assign div0     = div0_q;
  assign cmpo     = cmpo_q;

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised successor to the 8-bit multi-cycle ALU. Executes one operation per `start` using a decoded control word: operand zero/invert, then add/and/multiply/divide, then output invert.
- Multiply and divide are iterative: one bit per cycle, shift-add and restoring. This replaces single-cycle `*` and `/`.
- Adds a busy/done handshake, remainder output, divide-by-zero detect, and zero/negative flags.
- Sits between the register file/bus and the control unit.

Parameters:
- WIDTH, 8, datapath width in bits (must be ≥ 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin operation; sampled only in IDLE
- ctrl  in  10  decoded op, latched at start: [0]za [1]ia [2]zb [3]ib [4]io [5]po [6]high [7]cmp [9:8]csel (0 sum, 1 and, 2 mul, 3 div)
- a  in  WIDTH  operand A, latched at start
- b  in  WIDTH  operand B, latched at start
- carryin  in  1  chained carry for compare mode
- cmp_mode_wr  in  1  write cmp_mode from mode_val (IDLE only)
- sign_mode_wr  in  1  write signed_mode from mode_val (IDLE only)
- mode_val  in  1  mode write data
- oe  in  1  output enable for aluout/remout
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when result valid
- aluout  out  WIDTH  result when oe, else 0
- remout  out  WIDTH  division remainder when oe, else 0
- carryout  out  1  sum carry/borrow; 0 for other ops
- overout  out  1  signed overflow
- zero  out  1  result == 0
- neg  out  1  result MSB
- div0  out  1  last divide had zero divisor
- cmpo  out  1  pulses with done when ctrl.cmp=1

Behaviour:
- Reset: state IDLE. All outputs 0. cmp_mode=0, signed_mode=0. Result, remainder and flag registers cleared.
  - Reset mid-operation aborts the operation. No done pulse.
- States and transitions:
  - IDLE → PREP on start; start while busy is ignored.
  - PREP (1 cycle):
    - A' = (za ? 0 : a) ^ {WIDTH{ia}}; B' likewise with zb/ib.
    - For mul/div with signed_mode: capture sign bits and take magnitudes.
    - Load counter = WIDTH.
  - EXEC:
    - sum and and take 1 cycle.
    - mul takes WIDTH cycles: shift-add into a 2·WIDTH product.
    - div takes WIDTH cycles: restoring division, one quotient bit per cycle.
    - Counter decrements each cycle; leave EXEC when it reaches 0.
  - POST (1 cycle):
    - Apply sign correction; select product high/low by `high`.
    - XOR result with {WIDTH{io}}.
    - Register all flags; assert done and cmpo (if cmp).
    - Return to IDLE.
- Latency from the start edge to the done cycle: sum/and 3 cycles; mul/div WIDTH+3 cycles.
- Result and flags hold until the next accepted start.
- Mode writes take effect in IDLE only. If start and a mode write occur in the same cycle, the mode write applies first and the op uses the new mode.
- Sum: S = A' + B' + po + (cmp_mode & cmp & carryin), computed at WIDTH+1 bits.
  - carryout = ((ia|ib) & po) ? ~S[WIDTH] : S[WIDTH]; this is borrow semantics for subtract.
- overout:
  - sum/and: (~R[msb] & A'[msb] & B'[msb]) | (R[msb] & ~A'[msb] & ~B'[msb]).
  - mul: upper half not the sign-extension of the lower half.
  - div: signed MIN / -1.
- Divide:
  - Divisor 0 → quotient all ones, remainder = A', div0=1.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/-1 → quotient MIN, remainder 0, overout=1.
- zero, neg and overout are evaluated after io inversion. carryout is taken before inversion.

Test Plan (WIDTH=8):
- Add a=0x7F, b=0x01, ctrl=0x000 → done at +3 cycles; aluout=0x80, overout=1, carryout=0, neg=1.
- Sub a=0x05, b=0x07 with ib=1, po=1 → aluout=0xFE, carryout=1 (borrow); then a=0x07, b=0x05 → 0x02, carryout=0.
- Unsigned mul 0xFF·0xFF: low → 0x01, high → 0xFE, done at +11 cycles, busy high for cycles 1-10. Signed −3·5 → low 0xF1, high 0xFF, overout=0.
- Divide:
  - 100/7 → aluout 0x0E, remout 0x02.
  - Signed −100/7 → 0xF2, remout 0xFE.
  - 9/0 → aluout 0xFF, remout 0x09, div0=1.
  - Signed 0x80/0xFF → 0x80, overout=1.
- Pulse rst during the 4th EXEC cycle of a mul → next cycle busy=0, aluout=0, no done. A following add 2+3 returns 5.
- cmp_mode_wr=1 with mode_val=1, then sum with cmp=1, carryin=1, a=1, b=1 → aluout 0x03, cmpo pulses with done. start asserted while busy → ignored, single done pulse.
